// File: rtl/seq_mul16_cla.sv
// Sequential unsigned 16x16 shift-and-add multiplier built around one cla16x16.
// Optional build macro MUL_ZERO_SKIP_EN: a zero operand bypasses RUN and yields 0 one edge after accept.

module cla16x16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] sum_o,
  output logic        cout_o
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [4:0]  grp_c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Two-level lookahead: 4-bit group generate/propagate, then group carries.
  always_comb begin
    grp_g = '0;
    grp_p = '0;
    for (int i = 0; i < 4; i++) begin
      grp_p[i] = p[4*i+3] & p[4*i+2] & p[4*i+1] & p[4*i];
      grp_g[i] = g[4*i+3]
               | (p[4*i+3] & g[4*i+2])
               | (p[4*i+3] & p[4*i+2] & g[4*i+1])
               | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
    end
  end

  always_comb begin
    grp_c    = '0;
    grp_c[0] = cin_i;
    grp_c[1] = grp_g[0] | (grp_p[0] & grp_c[0]);
    grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & grp_c[0]);
    grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[2] & grp_p[1] & grp_p[0] & grp_c[0]);
    grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & grp_c[0]);
  end

  always_comb begin
    c = '0;
    for (int i = 0; i < 4; i++) begin
      c[4*i]   = grp_c[i];
      c[4*i+1] = g[4*i] | (p[4*i] & grp_c[i]);
      c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i]) | (p[4*i+1] & p[4*i] & grp_c[i]);
      c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1]) | (p[4*i+2] & p[4*i+1] & g[4*i])
               | (p[4*i+2] & p[4*i+1] & p[4*i] & grp_c[i]);
    end
  end

  assign sum_o  = p ^ c;
  assign cout_o = grp_c[4];

endmodule

module seq_mul16_cla #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; valid, once raised, is held with stable data until that edge.

  if (WIDTH != 16) begin : g_width_check
    $error("seq_mul16_cla: WIDTH must be 16 (bound to cla16x16)");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [WIDTH-1:0]    mcand_q;
  logic [2*WIDTH-1:0]  acc_q;
  logic [3:0]          count_q;
  logic [2*WIDTH-1:0]  out_p_q;
  logic                out_valid_q;

  logic [WIDTH-1:0]    addend;
  logic [WIDTH:0]      sum;
  logic [2*WIDTH-1:0]  acc_d;

  // The multiplier occupies acc_q[15:0]: its next bit is always acc_q[0], and
  // each shift retires one multiplier bit while a product bit enters from above.
  assign addend = acc_q[0] ? mcand_q : '0;

  cla16x16 u_cla (
    .a_i   (acc_q[2*WIDTH-1:WIDTH]),
    .b_i   (addend),
    .cin_i (1'b0),
    .sum_o (sum[WIDTH-1:0]),
    .cout_o(sum[WIDTH])
  );

  assign acc_d = {sum, acc_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      out_p_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            mcand_q <= in_a;
            acc_q   <= {{WIDTH{1'b0}}, in_b};
            count_q <= '0;
`ifdef MUL_ZERO_SKIP_EN
            if ((in_a == '0) || (in_b == '0)) begin
              out_p_q <= '0;
              state_q <= S_DONE;
            end else begin
              state_q <= S_RUN;
            end
`else
            state_q <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          acc_q   <= acc_d;
          count_q <= count_q + 4'd1;
          if (count_q == 4'd15) begin
            out_p_q     <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          // Entered with out_valid low only from the zero-skip path.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign busy      = (state_q == S_RUN);
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;

endmodule
